button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NB_BUTTONS, default 3: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required to accept a level change; legal range >= 1.
REQ-003 Parameter REPEAT_DELAY, default 50000000: held cycles before the first auto-repeat pulse (used only with the auto-repeat feature).
REQ-004 Parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses (used only with the auto-repeat feature).
REQ-005 i_clock  input  1  system clock; all logic on its rising edge.
REQ-006 i_reset  input  1  reset: synchronous, active-high.
REQ-007 i_buttons_raw  input  NB_BUTTONS  asynchronous, bouncing button levels; 1 = pressed.
REQ-008 o_pulse  output  NB_BUTTONS  one-cycle strobe per accepted press; drives the operand/operation load-enable bus of the value-load stage.
REQ-009 o_level  output  NB_BUTTONS  debounced, registered button level.

Function
REQ-010 Each bit of i_buttons_raw SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL run an independent FSM with states IDLE, DEB_PRESS, PRESSED, DEB_RELEASE and a counter sized to hold the largest of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-012 IDLE: synchronized input 1 -> DEB_PRESS with counter = 1; otherwise stay.
REQ-013 DEB_PRESS: input 0 -> IDLE, counter cleared, no pulse; input 1 with counter = DEBOUNCE_CYCLES -> PRESSED, o_pulse bit = 1 for exactly one cycle, o_level bit = 1; otherwise counter += 1.
REQ-014 PRESSED: input 0 -> DEB_RELEASE with counter = 1; otherwise stay.
REQ-015 DEB_RELEASE: input 1 -> PRESSED, no pulse; input 0 with counter = DEBOUNCE_CYCLES -> IDLE, o_level bit = 0; otherwise counter += 1.
REQ-016 A release SHALL never produce a pulse.
REQ-017 Latency: with raw input stable from edge 1, o_pulse SHALL be high in the cycle after edge 2+DEBOUNCE_CYCLES and low in the following cycle.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES SHALL be filtered without output change.
REQ-019 Channels SHALL be fully independent; simultaneous presses on several channels SHALL assert the corresponding o_pulse bits in the same cycle, with no priority or masking.
REQ-020 The counter SHALL saturate and never wrap, whatever the hold time.
REQ-021 o_pulse and o_level SHALL be driven directly from flops, with no combinational path from i_buttons_raw.

Reset
REQ-022 On i_reset: all channels go to IDLE, counters and synchronizer flops are cleared, and o_pulse and o_level are 0.
REQ-023 Reset asserted mid-debounce or mid-press SHALL abort the operation without emitting a pulse.
REQ-024 A button held while i_reset deasserts SHALL be treated as a new press, and SHALL pulse after the full latency of REQ-017.

Configuration
REQ-025 Macro BUTTON_CONDITIONER_AUTOREPEAT_EN defined: in PRESSED, the channel SHALL pulse after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles until it leaves PRESSED; the repeat counter SHALL restart on every PRESSED entry, including re-entry from DEB_RELEASE.
REQ-026 Macro not defined: exactly one pulse per accepted press, REPEAT_DELAY and REPEAT_PERIOD are ignored, and no repeat logic is synthesized.

Structure
REQ-027 Package button_conditioner_pkg SHALL hold the FSM state typedef (2-bit encoding) and the default constants for DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-028 Sub-module button_debounce_ch SHALL implement one channel (synchronizer, FSM, counter); the top SHALL instantiate NB_BUTTONS copies in a generate loop.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-029 Clean press: raw[0] 0->1 before edge 1 and held -> o_pulse=3'b001 in the cycle after edge 6 only; o_level[0]=1 from then on; release -> no pulse, o_level[0]=0 after the release debounce.
REQ-030 Bounce: raw[1] toggles 1,0,1,0 on successive cycles, then stays 0 -> o_pulse and o_level remain 0 throughout.
REQ-031 Simultaneous: raw=3'b111 applied on the same cycle -> o_pulse=3'b111 for one cycle after edge 6.
REQ-032 Reset mid-press: i_reset high in the cycle of counter=3 -> no pulse; raw still held after reset release -> pulse 6 edges after reset deasserts.
REQ-033 Long hold: macro undefined, held 100 cycles -> exactly 1 pulse; macro defined, held 100 cycles -> pulses at accept, accept+20, then every 8 cycles (accept+28, +36, ...).

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared types and defaults for the push-button conditioner.
//   - btn_state_e      : per-channel debounce FSM state (2-bit encoding)
//   - DEF_*            : default timing constants, in i_clock cycles
//   - cnt_width()      : counter width able to hold the largest timing value
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } btn_state_e;

    localparam int DEF_NB_BUTTONS      = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 10000000;

    // Width needed to hold max(a, b, c) without overflow.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// ---------------------------------------------------------------------------
// button_conditioner_if
//   Bundles the button bus between the board-side driver and the conditioner.
//   Signals:
//     i_buttons_raw [NB_BUTTONS]  raw, bouncing levels (1 = pressed)
//     o_pulse       [NB_BUTTONS]  one-cycle strobe per accepted press
//     o_level       [NB_BUTTONS]  debounced level
//   Modports:
//     master : drives raw levels, observes pulse/level (board / testbench)
//     slave  : the conditioner itself
// ---------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int NB_BUTTONS = 3
);
    logic [NB_BUTTONS-1:0] i_buttons_raw;
    logic [NB_BUTTONS-1:0] o_pulse;
    logic [NB_BUTTONS-1:0] o_level;

    modport master (
        output i_buttons_raw,
        input  o_pulse,
        input  o_level
    );

    modport slave (
        input  i_buttons_raw,
        output o_pulse,
        output o_level
    );
endinterface

// File: rtl/button_debounce_ch.sv
// ---------------------------------------------------------------------------
// button_debounce_ch
//   One button channel: 2-flop synchronizer, debounce FSM and a saturating
//   counter. Outputs come straight from flops.
//   Ports:
//     i_clock  in   system clock, rising edge
//     i_reset  in   synchronous, active-high reset
//     raw_i    in   raw asynchronous button level (1 = pressed)
//     pulse_o  out  one-cycle strobe when a press is accepted
//     level_o  out  debounced level
//   Optional feature: BUTTON_CONDITIONER_AUTOREPEAT_EN adds auto-repeat
//   pulses while the button stays in PRESSED.
// ---------------------------------------------------------------------------
module button_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic raw_i,
    output logic pulse_o,
    output logic level_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    // The cycle that moves the FSM out of IDLE/PRESSED already counts as the
    // first stable cycle, so acceptance happens when the counter holds
    // DEBOUNCE_CYCLES-1 and the input is still stable: that edge is the
    // DEBOUNCE_CYCLES-th stable sample.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               DEB_ONE  = (DEBOUNCE_CYCLES <= 1);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    logic rpt_q;   // 0: waiting for first repeat, 1: periodic repeats
`endif

    logic             sync1_q, sync2_q;
    btn_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q, level_q;

    // Saturating increment: the counter never wraps, however long the hold.
    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            rpt_q   <= 1'b0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sync2_q) begin
                        if (DEB_ONE) begin
                            state_q <= ST_PRESSED;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                            level_q <= 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                            rpt_q   <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_DEB_PRESS;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                end

                ST_DEB_PRESS: begin
                    if (!sync2_q) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                        rpt_q   <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_PRESSED: begin
                    if (!sync2_q) begin
                        if (DEB_ONE) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                        end else begin
                            state_q <= ST_DEB_RELEASE;
                            cnt_q   <= CNT_ONE;
                        end
                    end
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                    // Counter runs from 0 on PRESSED entry; first repeat after
                    // REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
                    else if (cnt_q >= (rpt_q ? PER_LAST : DLY_LAST)) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= '0;
                        rpt_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
`endif
                end

                ST_DEB_RELEASE: begin
                    if (sync2_q) begin
                        // Release bounce: back to PRESSED, no new pulse.
                        state_q <= ST_PRESSED;
                        cnt_q   <= '0;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
                        rpt_q   <= 1'b0;
`endif
                    end else if (cnt_q >= DEB_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   NB_BUTTONS independent debounce channels. Each accepted press gives a
//   one-cycle strobe on o_pulse (load-enable bus of the value-load stage) and
//   a debounced level on o_level. No priority between channels.
//   Ports:
//     i_clock  in     system clock, rising edge
//     i_reset  in     synchronous, active-high reset
//     btn_if   slave  i_buttons_raw in, o_pulse / o_level out
//   Optional feature: define BUTTON_CONDITIONER_AUTOREPEAT_EN for auto-repeat
//   (REPEAT_DELAY / REPEAT_PERIOD); otherwise those parameters only size the
//   counter.
// ---------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NB_BUTTONS      = DEF_NB_BUTTONS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                i_clock,
    input  logic                i_reset,
    button_conditioner_if.slave btn_if
);

    logic [NB_BUTTONS-1:0] pulse_w;
    logic [NB_BUTTONS-1:0] level_w;

    for (genvar g = 0; g < NB_BUTTONS; g++) begin : g_ch
        button_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .raw_i   (btn_if.i_buttons_raw[g]),
            .pulse_o (pulse_w[g]),
            .level_o (level_w[g])
        );
    end

    assign btn_if.o_pulse = pulse_w;
    assign btn_if.o_level = level_w;

endmodule
